bcd_mmss_counter: RTL and testbench

- Parametrised BCD minutes:seconds counter, MM:SS, four BCD digits.
- Generalises the existing single-seconds / tens-of-seconds cascade.
- Adds a built-in prescaler, up/down counting, parallel load with digit validation, alarm compare and event pulses.
- Drives display and timer logic from a free-running enable strobe.

---
 rtl/bcd_mmss_counter.sv | 111 +++++++++++
 tb/tb_bcd_mmss_counter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_mmss_counter.sv
// BCD MM:SS counter with prescaler, up/down stepping, validated parallel load,
// alarm compare and one-cycle event pulses; every output is registered.
module bcd_mmss_counter #(
    parameter int TICK_DIV = 1,
    parameter int ST_MAX   = 5,
    parameter int MT_MAX   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        up_dn,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic [15:0] alarm_val,
    output logic [3:0]  so,
    output logic [3:0]  st,
    output logic [3:0]  mo,
    output logic [3:0]  mt,
    output logic        step,
    output logic        wrap,
    output logic        alarm,
    output logic        load_err
);

    localparam logic [3:0]  ST4   = 4'(ST_MAX);
    localparam logic [3:0]  MT4   = 4'(MT_MAX);
    localparam logic [15:0] TLAST = 16'(TICK_DIV - 1);

    logic [15:0] pcnt;
    logic        step_cyc, valid, ld_ok, ld_bad;
    logic [3:0]  nso, nst, nmo, nmt;
    logic        nwrap;

    assign step_cyc = enable && (pcnt == TLAST);
    assign valid    = (load_val[3:0] <= 4'd9) && (load_val[7:4] <= ST4) &&
                      (load_val[11:8] <= 4'd9) && (load_val[15:12] <= MT4);
    assign ld_ok    = load && valid;
    assign ld_bad   = load && !valid;

    // Next count for one step; each digit only moves when every lower digit rolls.
    always_comb begin
        nso   = so;
        nst   = st;
        nmo   = mo;
        nmt   = mt;
        nwrap = 1'b0;
        if (up_dn) begin
            nwrap = (mt == MT4) && (mo == 4'd9) && (st == ST4) && (so == 4'd9);
            if (so != 4'd9) nso = so + 4'd1;
            else begin
                nso = 4'd0;
                if (st != ST4) nst = st + 4'd1;
                else begin
                    nst = 4'd0;
                    if (mo != 4'd9) nmo = mo + 4'd1;
                    else begin
                        nmo = 4'd0;
                        nmt = (mt == MT4) ? 4'd0 : mt + 4'd1;
                    end
                end
            end
        end else begin
            nwrap = (mt == 4'd0) && (mo == 4'd0) && (st == 4'd0) && (so == 4'd0);
            if (so != 4'd0) nso = so - 4'd1;
            else begin
                nso = 4'd9;
                if (st != 4'd0) nst = st - 4'd1;
                else begin
                    nst = ST4;
                    if (mo != 4'd0) nmo = mo - 4'd1;
                    else begin
                        nmo = 4'd9;
                        nmt = (mt == 4'd0) ? MT4 : mt - 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt     <= '0;
            {mt, mo, st, so} <= '0;
            step     <= 1'b0;
            wrap     <= 1'b0;
            alarm    <= 1'b0;
            load_err <= 1'b0;
        end else begin
            step     <= 1'b0;
            wrap     <= 1'b0;
            alarm    <= 1'b0;
            load_err <= ld_bad;
            // A valid load swallows any step due this cycle; a rejected one does not.
            if (ld_ok) begin
                {mt, mo, st, so} <= load_val;
                pcnt <= '0;
            end else if (enable) begin
                if (step_cyc) begin
                    pcnt  <= '0;
                    {mt, mo, st, so} <= {nmt, nmo, nst, nso};
                    step  <= 1'b1;
                    wrap  <= nwrap;
                    alarm <= ({nmt, nmo, nst, nso} == alarm_val);
                end else begin
                    pcnt <= pcnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_mmss_counter.sv
// Directed bench: three instances (step-every-cycle 59:59, step-every-cycle
// 99:59, divide-by-4) driven through counting, wrap, load, alarm and reset.
module tb_bcd_mmss_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // shared stimulus for u1 (MT_MAX=5) and u9 (MT_MAX=9)
    logic        reset = 1'b1, enable = 1'b0, up_dn = 1'b1, load = 1'b0;
    logic [15:0] load_val = '0, alarm_val = 16'h0005;
    logic [3:0]  so1, st1, mo1, mt1, so9, st9, mo9, mt9;
    logic        step1, wrap1, alarm1, lerr1, step9, wrap9, alarm9, lerr9;

    // divide-by-4 instance
    logic        r4 = 1'b1, e4 = 1'b0, l4 = 1'b0;
    logic [15:0] lv4 = '0;
    logic [3:0]  so4, st4, mo4, mt4;
    logic        step4, wrap4, alarm4, lerr4;

    bcd_mmss_counter #(.TICK_DIV(1), .ST_MAX(5), .MT_MAX(5)) u1 (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(load_val), .alarm_val(alarm_val), .so(so1), .st(st1), .mo(mo1),
        .mt(mt1), .step(step1), .wrap(wrap1), .alarm(alarm1), .load_err(lerr1));

    bcd_mmss_counter #(.TICK_DIV(1), .ST_MAX(5), .MT_MAX(9)) u9 (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(load_val), .alarm_val(alarm_val), .so(so9), .st(st9), .mo(mo9),
        .mt(mt9), .step(step9), .wrap(wrap9), .alarm(alarm9), .load_err(lerr9));

    bcd_mmss_counter #(.TICK_DIV(4), .ST_MAX(5), .MT_MAX(5)) u4 (
        .clk(clk), .reset(r4), .enable(e4), .up_dn(1'b1), .load(l4),
        .load_val(lv4), .alarm_val(16'hFFFF), .so(so4), .st(st4), .mo(mo4),
        .mt(mt4), .step(step4), .wrap(wrap4), .alarm(alarm4), .load_err(lerr4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // flags order: {step, wrap, alarm, load_err}
    task automatic chk1(input string tag, input logic [15:0] ed, input logic [3:0] ef);
        chk({tag, " u1 digits"}, {mt1, mo1, st1, so1}, ed);
        chk({tag, " u1 flags"}, {12'd0, step1, wrap1, alarm1, lerr1}, {12'd0, ef});
    endtask

    task automatic chk9(input string tag, input logic [15:0] ed, input logic [3:0] ef);
        chk({tag, " u9 digits"}, {mt9, mo9, st9, so9}, ed);
        chk({tag, " u9 flags"}, {12'd0, step9, wrap9, alarm9, lerr9}, {12'd0, ef});
    endtask

    task automatic chk4(input string tag, input logic [15:0] ed, input logic [3:0] ef);
        chk({tag, " u4 digits"}, {mt4, mo4, st4, so4}, ed);
        chk({tag, " u4 flags"}, {12'd0, step4, wrap4, alarm4, lerr4}, {12'd0, ef});
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        int mm, ss;
        mm = n / 60;
        ss = n % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    logic pat [10] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1};

    initial begin
        // reset
        tick();
        chk1("reset", 16'h0000, 4'b0000);
        chk9("reset", 16'h0000, 4'b0000);
        chk4("reset", 16'h0000, 4'b0000);
        reset = 1'b0;
        r4    = 1'b0;
        enable = 1'b1;

        // full hour up-count, alarm at 00:05, single wrap at 00:00
        for (int i = 1; i <= 3600; i++) begin
            tick();
            chk1("upcount", to_bcd(i % 3600),
                 {1'b1, i == 3600, i == 5, 1'b0});
        end
        chk9("upcount 60:00", 16'h6000, 4'b1000);

        // load equal to alarm value gives no alarm or step
        load = 1'b1; load_val = 16'h0005;
        tick();
        chk1("load alarm val", 16'h0005, 4'b0000);
        chk9("load alarm val", 16'h0005, 4'b0000);

        // down count through zero
        load_val = 16'h0001;
        tick();
        chk1("load 00:01", 16'h0001, 4'b0000);
        load = 1'b0; up_dn = 1'b0;
        tick();
        chk1("down 00:00", 16'h0000, 4'b1000);
        chk9("down 00:00", 16'h0000, 4'b1000);
        tick();
        chk1("down wrap", 16'h5959, 4'b1100);
        chk9("down wrap", 16'h9959, 4'b1100);
        alarm_val = 16'h5958;
        tick();
        chk1("down alarm", 16'h5958, 4'b1010);
        chk9("down no alarm", 16'h9958, 4'b1000);
        up_dn = 1'b1;
        tick();
        chk1("dir toggle", 16'h5959, 4'b1000);
        chk9("dir toggle", 16'h9959, 4'b1000);

        // 60:00 is invalid only when MT_MAX=5; rejected load still steps
        load = 1'b1; load_val = 16'h6000;
        tick();
        chk1("bad load mt", 16'h0000, 4'b1101);
        chk9("good load 60", 16'h6000, 4'b0000);
        load_val = 16'h000A;
        tick();
        chk1("bad load so", 16'h0001, 4'b1001);
        chk9("bad load so", 16'h6001, 4'b1001);
        load = 1'b0; enable = 1'b0;
        tick();
        chk1("hold", 16'h0001, 4'b0000);
        chk9("hold", 16'h6001, 4'b0000);
        reset = 1'b1; load = 1'b1; load_val = 16'h1234; enable = 1'b1;
        tick();
        chk1("reset over load", 16'h0000, 4'b0000);
        chk9("reset over load", 16'h0000, 4'b0000);
        reset = 1'b0; load = 1'b0; enable = 1'b0;

        // prescaler with enable gaps
        for (int i = 0; i < 10; i++) begin
            e4 = pat[i];
            tick();
            chk4($sformatf("presc %0d", i),
                 (i >= 9) ? 16'h0002 : (i >= 5) ? 16'h0001 : 16'h0000,
                 {(i == 5 || i == 9), 3'b000});
        end

        // load with a step due: step discarded, prescaler restarts
        e4 = 1'b1;
        repeat (3) tick();
        chk4("pre load", 16'h0002, 4'b0000);
        l4 = 1'b1; lv4 = 16'h5958;
        tick();
        chk4("load step due", 16'h5958, 4'b0000);
        l4 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk4($sformatf("post load %0d", i), (i == 4) ? 16'h5959 : 16'h5958,
                 {i == 4, 3'b000});
        end

        // reset mid-count at 12:34 with pcnt=2
        l4 = 1'b1; lv4 = 16'h1234;
        tick();
        l4 = 1'b0;
        repeat (2) tick();
        chk4("pre reset", 16'h1234, 4'b0000);
        r4 = 1'b1;
        tick();
        chk4("mid reset", 16'h0000, 4'b0000);
        r4 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk4($sformatf("post reset %0d", i), (i == 4) ? 16'h0001 : 16'h0000,
                 {i == 4, 3'b000});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
